// File: rtl/serial_parity_checker_4bit.sv
// serial_parity_checker_4bit: deserialises start/data/parity/stop frames and checks parity into a one-entry output buffer
module serial_parity_checker_4bit #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              parity_mode,
  input  logic              rx_valid,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  frm_err_cnt
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0] bit_cnt;
  logic mode_l, rx_par, perr, free, stop_ok, stop_bad;
  assign perr     = rx_par != (mode_l ? ~^sr : ^sr);
  assign free     = !out_valid || out_ready;
  assign stop_ok  = rx_valid && state == STOP && rx_bit;
  assign stop_bad = rx_valid && state == STOP && !rx_bit;
  always_comb begin
    state_nx = state;
    if (rx_valid)
      case (state)
        IDLE:    state_nx = rx_bit ? IDLE : DATA;
        DATA:    state_nx = bit_cnt == BW'(DATA_W - 1) ? PARITY : DATA;
        PARITY:  state_nx = STOP;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr          <= '0;
      bit_cnt     <= '0;
      mode_l      <= 1'b0;
      rx_par      <= 1'b0;
      data_out    <= '0;
      parity_err  <= 1'b0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      par_err_cnt <= '0;
      frm_err_cnt <= '0;
    end else begin
      if (rx_valid && state == IDLE && !rx_bit) begin
        sr      <= '0;
        bit_cnt <= '0;
        mode_l  <= parity_mode;
      end
      if (rx_valid && state == DATA) begin
        sr      <= {sr[DATA_W-2:0], rx_bit};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (rx_valid && state == PARITY) rx_par <= rx_bit;
      // a same-cycle accept frees the buffer for the incoming word
      if (stop_ok && free) begin
        data_out   <= sr;
        parity_err <= perr;
        out_valid  <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      if (stop_ok && !free) overrun <= 1'b1;
      if (stop_ok && free && perr && par_err_cnt != '1) par_err_cnt <= par_err_cnt + 1'b1;
      if (stop_bad && frm_err_cnt != '1) frm_err_cnt <= frm_err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_parity_checker_4bit.sv
// tb_serial_parity_checker_4bit: vector table plus corner sequences, delivered words checked through a scoreboard queue
module tb_serial_parity_checker_4bit;
  logic clk = 0, rst = 1, parity_mode = 0, rx_valid = 0, rx_bit = 1, out_ready = 1;
  logic [3:0] data_out;
  logic parity_err, out_valid, overrun;
  logic [7:0] par_err_cnt, frm_err_cnt;
  int n_chk = 0, n_pass = 0, exp_par = 0, exp_frm = 0;
  logic [4:0] q[$];
  typedef struct {logic mode; logic [3:0] data; logic par; logic stop; logic perr;} vec_t;
  vec_t vecs[8];

  serial_parity_checker_4bit dut (
    .clk(clk), .rst(rst), .parity_mode(parity_mode), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .data_out(data_out), .parity_err(parity_err), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_word", {parity_err, data_out}, -1);
      else check("word", {parity_err, data_out}, q.pop_front());
    end
  end

  task automatic send_bit(input logic b, input bit stall);
    if (stall) begin
      rx_valid = 0; rx_bit = ~b;
      @(posedge clk); #1;
    end
    rx_valid = 1; rx_bit = b;
    @(posedge clk); #1;
    rx_valid = 0; rx_bit = 1;
  endtask

  task automatic send_frame(input logic mode, input logic [3:0] d, input logic par, input logic stop,
                            input bit stall, input bit flip);
    parity_mode = mode;
    send_bit(1'b0, stall);
    if (flip) parity_mode = ~mode;
    for (int i = 3; i >= 0; i--) send_bit(d[i], stall);
    send_bit(par, stall);
    send_bit(stop, stall);
    parity_mode = mode;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_par_cnt"}, par_err_cnt, exp_par);
    check({tag, "_frm_cnt"}, frm_err_cnt, exp_frm);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 4'b0111, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'b0111, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'b0110, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'b1001, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 4'b1000, 1'b1, 1'b1, 1'b1};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_overrun", overrun, 0);
    check_counts("rst");
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].stop) q.push_back({vecs[i].perr, vecs[i].data});
      if (vecs[i].stop && vecs[i].perr) exp_par++;
      if (!vecs[i].stop) exp_frm++;
      send_frame(vecs[i].mode, vecs[i].data, vecs[i].par, vecs[i].stop, 0, 0);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].stop);
      check_counts($sformatf("vec%0d", i));
    end
    q.push_back({1'b0, 4'b1010});
    send_frame(1'b0, 4'b1010, 1'b0, 1'b1, 1, 1);
    check("stall_valid", out_valid, 1);
    check_counts("stall");
    @(posedge clk); #1;
    check("pre_bp_overrun", overrun, 0);
    out_ready = 0;
    q.push_back({1'b0, 4'b0001});
    send_frame(1'b0, 4'b0001, 1'b1, 1'b1, 0, 0);
    check("bp_valid1", out_valid, 1);
    send_frame(1'b0, 4'b1110, 1'b1, 1'b1, 0, 0);
    check("bp_held_data", data_out, 4'b0001);
    check("bp_overrun", overrun, 1);
    check("bp_valid2", out_valid, 1);
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_drop", out_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    check_counts("bp");
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_par = 0; exp_frm = 0;
    check("rst2_valid", out_valid, 0);
    check("rst2_data", data_out, 0);
    check("rst2_perr", parity_err, 0);
    check("rst2_overrun", overrun, 0);
    check_counts("rst2");
    q.push_back({1'b0, 4'b0101});
    send_frame(1'b0, 4'b0101, 1'b0, 1'b1, 0, 0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_perr", parity_err, 0);
    for (int i = 0; i < 259; i++) begin
      q.push_back({1'b1, 4'b0011});
      if (exp_par < 255) exp_par++;
      send_frame(1'b1, 4'b0011, 1'b0, 1'b1, 0, 0);
    end
    check_counts("sat");
    check("sat_all_ones", par_err_cnt, 8'hFF);
    repeat (3) @(posedge clk);
    #1 check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
